// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I constants for the register-register ALU dispatcher:
//   - base R-type opcode and funct7 value
//   - funct3 encodings of the base ALU operations (ADD..AND)
//   - dispatcher state encoding
//   - a small decode helper that checks whether a word is a base R-type op
// ----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0] RV_OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] RV_FUNCT7_BASE = 7'b0000000;

    // funct3 encodings of the base register-register ALU operations
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Dispatcher states. ST_REJECT is the single cycle in which an
    // unsupported word is reported before returning to ST_IDLE.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_READ   = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_REJECT = 3'd5;

    // True when the word carries the accepted opcode and funct7.
    function automatic logic is_alu_rr(input logic [31:0] word,
                                       input logic [6:0]  opcode,
                                       input logic [6:0]  funct7);
        return (word[6:0] == opcode) && (word[31:25] == funct7);
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// ----------------------------------------------------------------------------
// rv32i_regfile
// 32 x 32-bit integer register file, x0 hardwired to zero.
// Ports:
//   clock, reset_n          - clock and asynchronous active-low clear
//   rs1_addr / rs1_data     - asynchronous read port 1
//   rs2_addr / rs2_data     - asynchronous read port 2
//   dbg_addr / dbg_data     - asynchronous debug read port
//   wr_en, wr_addr, wr_data - single write port (writes to x0 are dropped)
// ----------------------------------------------------------------------------
module rv32i_regfile (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    // Entry 0 is cleared on reset and never written, so it always holds zero;
    // the read muxes below additionally force zero for index 0.
    logic [31:0] regs_reg [0:31];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs_reg[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs_reg[rs2_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_reg[dbg_addr];

endmodule

// File: rtl/alu_rr_dispatch.sv
// ----------------------------------------------------------------------------
// alu_rr_dispatch
// Multi-cycle dispatcher for RV32I register-register ALU instructions.
// One instruction in flight; sequence IDLE -> READ -> EXEC -> WAIT -> WB.
// Ports:
//   clock, reset_n                  - clock, asynchronous active-low reset
//   instr_valid/instr_ready, instruction - instruction handshake (IDLE only)
//   alu_base_enable, funct3         - execute strobe and operation select
//   rs1_value, rs2_value            - operand registers to the ALU
//   rd_value                        - registered ALU result (cycle after strobe)
//   wb_valid, wb_rd, wb_value       - write-back report pulse
//   illegal                         - rejected-instruction pulse
//   load_we, load_addr, load_data   - register preload (IDLE only)
//   dbg_addr, dbg_data              - combinational register debug read
// ----------------------------------------------------------------------------
module alu_rr_dispatch
    import rv32i_pkg::*;
#(
    parameter logic [6:0] OPCODE_OP   = RV_OPCODE_OP,
    parameter logic [6:0] FUNCT7_BASE = RV_FUNCT7_BASE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instruction,
    output logic        alu_base_enable,
    output logic [2:0]  funct3,
    output logic [31:0] rs1_value,
    output logic [31:0] rs2_value,
    input  logic [31:0] rd_value,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_value,
    output logic        illegal,
    input  logic        load_we,
    input  logic [4:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    logic [2:0]  state_reg, state_next;
    // Only instruction[24:7] (rd, funct3, rs1, rs2) is needed after decode.
    logic [17:0] fields_reg;
    logic [31:0] rs1_reg, rs2_reg;
    logic [31:0] result_reg;

    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        handshake;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    assign rd_idx  = fields_reg[4:0];
    assign rs1_idx = fields_reg[12:8];
    assign rs2_idx = fields_reg[17:13];

    assign instr_ready = (state_reg == ST_IDLE);
    assign handshake   = instr_valid && instr_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = is_alu_rr(instruction, OPCODE_OP, FUNCT7_BASE)
                                 ? ST_READ : ST_REJECT;
                end
            end
            ST_READ:   state_next = ST_EXEC;
            ST_EXEC:   state_next = ST_WAIT;
            ST_WAIT:   state_next = ST_WB;
            ST_WB:     state_next = ST_IDLE;
            ST_REJECT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            fields_reg <= '0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Rejected words are not latched so the ALU-side outputs keep
            // describing the last legal instruction.
            if (handshake && is_alu_rr(instruction, OPCODE_OP, FUNCT7_BASE)) begin
                fields_reg <= instruction[24:7];
            end
            if (state_reg == ST_READ) begin
                rs1_reg <= rf_rs1_data;
                rs2_reg <= rf_rs2_data;
            end
            // The ALU result bus is only meaningful during WAIT.
            if (state_reg == ST_WAIT) begin
                result_reg <= rd_value;
            end
        end
    end

    // Write port: write-back in WB, preload only while IDLE. Preload during
    // the handshake cycle lands before READ, so the new value is observed.
    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = load_addr;
        rf_wr_data = load_data;
        if (state_reg == ST_WB) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = rd_idx;
            rf_wr_data = result_reg;
        end else if (state_reg == ST_IDLE && load_we) begin
            rf_wr_en   = 1'b1;
        end
    end

    rv32i_regfile u_regfile (
        .clock    (clock),
        .reset_n  (reset_n),
        .rs1_addr (rs1_idx),
        .rs1_data (rf_rs1_data),
        .rs2_addr (rs2_idx),
        .rs2_data (rf_rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wr_en    (rf_wr_en),
        .wr_addr  (rf_wr_addr),
        .wr_data  (rf_wr_data)
    );

    // All strobes decode from distinct states, so they are mutually exclusive.
    assign alu_base_enable = (state_reg == ST_EXEC);
    assign wb_valid        = (state_reg == ST_WB);
    assign illegal         = (state_reg == ST_REJECT);
    assign funct3          = fields_reg[7:5];
    assign rs1_value       = rs1_reg;
    assign rs2_value       = rs2_reg;
    assign wb_rd           = rd_idx;
    assign wb_value        = result_reg;

endmodule

// File: tb/tb_alu_rr_dispatch.sv
// ----------------------------------------------------------------------------
// tb_alu_rr_dispatch
// Directed test of alu_rr_dispatch with a one-cycle registered ALU model.
// ----------------------------------------------------------------------------
module tb_alu_rr_dispatch;

    logic        clock;
    logic        reset_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        alu_base_enable;
    logic [2:0]  funct3;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [31:0] rd_value;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        illegal;
    logic        load_we;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_rr_dispatch dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .alu_base_enable (alu_base_enable),
        .funct3          (funct3),
        .rs1_value       (rs1_value),
        .rs2_value       (rs2_value),
        .rd_value        (rd_value),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_value        (wb_value),
        .illegal         (illegal),
        .load_we         (load_we),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One-cycle registered ALU. Outside the result cycle it drives a poison
    // value so that a capture in the wrong state is visible.
    logic [31:0] alu_q = 32'd0;
    logic        alu_drive = 1'b0;

    function automatic logic [31:0] alu_fn(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (f3)
            3'b000:  return a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b101:  return a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always @(posedge clock) begin
        alu_drive <= alu_base_enable;
        if (alu_base_enable) alu_q <= alu_fn(funct3, rs1_value, rs2_value);
    end
    assign rd_value = alu_drive ? alu_q : 32'hDEAD_BEEF;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        load_we   = 1'b1;
        load_addr = idx;
        load_data = val;
        step();
        load_we   = 1'b0;
    endtask

    // Full legal instruction: handshake in cycle 0, write-back in cycle 4,
    // instr_ready back in cycle 5.
    task automatic run_legal(input string tag, input logic [31:0] instr,
                             input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input logic [31:0] exp_val);
        instr_valid = 1'b1;
        instruction = instr;
        check({tag, " ready"}, 32'(instr_ready), 32'd1);
        step();                                   // READ
        instr_valid = 1'b0;
        check({tag, " busy"}, 32'(instr_ready), 32'd0);
        step();                                   // EXEC
        check({tag, " alu_en"}, 32'(alu_base_enable), 32'd1);
        check({tag, " funct3"}, 32'(funct3), 32'(instr[14:12]));
        check({tag, " rs1"}, rs1_value, exp_a);
        check({tag, " rs2"}, rs2_value, exp_b);
        step();                                   // WAIT
        check({tag, " alu_en_off"}, 32'(alu_base_enable), 32'd0);
        check({tag, " wb_early"}, 32'(wb_valid), 32'd0);
        step();                                   // WB
        check({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, " wb_rd"}, 32'(wb_rd), 32'(instr[11:7]));
        check({tag, " wb_value"}, wb_value, exp_val);
        check({tag, " excl"}, 32'(illegal | alu_base_enable), 32'd0);
        step();                                   // IDLE
        check({tag, " ready_back"}, 32'(instr_ready), 32'd1);
        check({tag, " wb_done"}, 32'(wb_valid), 32'd0);
        $display("txn %s instr=%h wb_value=%h", tag, instr, wb_value);
    endtask

    task automatic run_illegal(input string tag, input logic [31:0] instr);
        instr_valid = 1'b1;
        instruction = instr;
        step();
        instr_valid = 1'b0;
        check({tag, " illegal"}, 32'(illegal), 32'd1);
        check({tag, " no_wb"}, 32'(wb_valid), 32'd0);
        check({tag, " no_alu"}, 32'(alu_base_enable), 32'd0);
        check({tag, " busy"}, 32'(instr_ready), 32'd0);
        step();
        check({tag, " illegal_off"}, 32'(illegal), 32'd0);
        check({tag, " ready_back"}, 32'(instr_ready), 32'd1);
        $display("txn %s instr=%h rejected", tag, instr);
    endtask

    initial begin
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'd0;
        load_we     = 1'b0;
        load_addr   = 5'd0;
        load_data   = 32'd0;
        dbg_addr    = 5'd0;
        #2;
        check("rst ready", 32'(instr_ready), 32'd1);
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst illegal", 32'(illegal), 32'd0);
        check("rst alu_en", 32'(alu_base_enable), 32'd0);
        check("rst funct3", 32'(funct3), 32'd0);
        check("rst wb_rd", 32'(wb_rd), 32'd0);
        check("rst wb_value", wb_value, 32'd0);
        check("rst rs1", rs1_value, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // ADD x3,x1,x2 with x1=5, x2=7
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_legal("add_x3", 32'h002081B3, 32'd5, 32'd7, 32'd12);
        check_reg("dbg x3", 5'd3, 32'd12);

        // Signed vs unsigned compare
        preload(5'd1, 32'hFFFF_FFFF);
        preload(5'd2, 32'd1);
        run_legal("slt_x4", enc(7'h00, 5'd2, 5'd1, 3'b010, 5'd4, 7'h33),
                  32'hFFFF_FFFF, 32'd1, 32'd1);
        check_reg("dbg x4", 5'd4, 32'd1);
        run_legal("sltu_x5", enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd5, 7'h33),
                  32'hFFFF_FFFF, 32'd1, 32'd0);
        check_reg("dbg x5", 5'd5, 32'd0);

        // Write-back to x0 is reported but discarded
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        run_legal("add_x0", enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, 7'h33),
                  32'd5, 32'd7, 32'd12);
        check_reg("dbg x0", 5'd0, 32'd0);

        // Rejected encodings leave registers untouched
        run_illegal("sub_x6", enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd6, 7'h33));
        run_illegal("addi_x6", enc(7'h00, 5'd7, 5'd1, 3'b000, 5'd6, 7'h13));
        check_reg("dbg x6 after illegal", 5'd6, 32'd0);
        check_reg("dbg x3 after illegal", 5'd3, 32'd12);

        // Back-to-back dependent instructions
        preload(5'd1, 32'd3);
        run_legal("add_x1_a", enc(7'h00, 5'd1, 5'd1, 3'b000, 5'd1, 7'h33),
                  32'd3, 32'd3, 32'd6);
        run_legal("add_x1_b", enc(7'h00, 5'd1, 5'd1, 3'b000, 5'd1, 7'h33),
                  32'd6, 32'd6, 32'd12);
        check_reg("dbg x1", 5'd1, 32'd12);

        // Preload in the handshake cycle is seen by READ; preload while busy
        // is ignored.
        load_we     = 1'b1;
        load_addr   = 5'd2;
        load_data   = 32'd10;
        instr_valid = 1'b1;
        instruction = enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd8, 7'h33);
        step();                                   // READ
        instr_valid = 1'b0;
        load_addr   = 5'd7;
        load_data   = 32'h55;
        step();                                   // EXEC
        check("hs_load rs2", rs2_value, 32'd10);
        step();                                   // WAIT
        step();                                   // WB
        check("hs_load wb_value", wb_value, 32'd22);
        load_we = 1'b0;
        step();                                   // IDLE
        check_reg("busy load x7", 5'd7, 32'd0);
        check_reg("dbg x8", 5'd8, 32'd22);
        $display("txn hs_load x8=%h", dbg_data);

        // Reset during EXEC aborts the instruction
        instr_valid = 1'b1;
        instruction = enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'h33);
        step();                                   // READ
        instr_valid = 1'b0;
        step();                                   // EXEC
        check("abort in_exec", 32'(alu_base_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort alu_en", 32'(alu_base_enable), 32'd0);
        check("abort ready", 32'(instr_ready), 32'd1);
        for (int r = 0; r < 32; r++) begin
            check_reg($sformatf("abort dbg x%0d", r), 5'(r), 32'd0);
        end
        step();
        reset_n = 1'b1;
        step();
        check("post_rst ready", 32'(instr_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check("post_rst no_wb", 32'(wb_valid), 32'd0);
            step();
        end
        check_reg("post_rst x9", 5'd9, 32'd0);
        $display("txn reset_abort done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
